// File: rtl/regfile_write_sequencer_pkg.sv
// Shared types and widths for the register-file write path.
package regfile_write_sequencer_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = AW'(0);

    // One pending register write; also produced by the execute/load units
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/regfile_write_sequencer_if.sv
// Request handshake and register-file write port of the write sequencer.
interface regfile_write_sequencer_if
    import regfile_write_sequencer_pkg::*;
    ;

    logic            wr_valid;
    logic            wr_ready;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [AW-1:0]   rf_a3;
    logic [XLEN-1:0] rf_wd3;
    logic            rf_we;

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready, rf_a3, rf_wd3, rf_we
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready, rf_a3, rf_wd3, rf_we
    );

endinterface

// File: rtl/regfile_write_sequencer_fwd_match.sv
// Youngest-match search of a read address over the valid FIFO entries.
module rf_fwd_match
    import regfile_write_sequencer_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  rf_wr_t          entries [DEPTH],
    input  logic [PW-1:0]   rd_ptr,
    input  logic [CW-1:0]   count,
    input  logic [AW-1:0]   rd_addr,
    output logic            hit_c,
    output logic [XLEN-1:0] data_c
);

    // Walk oldest to youngest so the last match (youngest) wins
    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count) && (rd_addr != REG_ZERO) &&
                (entries[PW'(rd_ptr + PW'(k))].addr == rd_addr)) begin
                hit_c  = 1'b1;
                data_c = entries[PW'(rd_ptr + PW'(k))].data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_sequencer.sv
// In-order write FIFO draining one entry per cycle into the register file,
// with forwarding of pending writes to both read ports.
module regfile_write_sequencer
    import regfile_write_sequencer_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    regfile_write_sequencer_if.slave   bus,
    input  logic                       hold,
    input  logic [AW-1:0]              rd_addr1,
    input  logic [AW-1:0]              rd_addr2,
    output logic                       fwd1_hit,
    output logic [XLEN-1:0]            fwd1_data,
    output logic                       fwd2_hit,
    output logic [XLEN-1:0]            fwd2_data,
    output logic [CW-1:0]              occupancy,
    output logic                       empty
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    rf_wr_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Ready looks only at the registered count, never at a same-cycle pop
    assign bus.wr_ready = (count < CW'(DEPTH));
    assign push         = bus.wr_valid & bus.wr_ready & (bus.wr_addr != REG_ZERO);
    assign pop          = (count != '0) & ~hold;

    assign empty     = (count == '0);
    assign occupancy = count;

    assign bus.rf_we  = pop;
    assign bus.rf_a3  = empty ? REG_ZERO : mem[rd_ptr].addr;
    assign bus.rf_wd3 = empty ? '0       : mem[rd_ptr].data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{addr: bus.wr_addr, data: bus.wr_data};
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    rf_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (mem),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .rd_addr (rd_addr1),
        .hit_c   (fwd1_hit),
        .data_c  (fwd1_data)
    );

    rf_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (mem),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .rd_addr (rd_addr2),
        .hit_c   (fwd2_hit),
        .data_c  (fwd2_data)
    );

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Self-checking bench for regfile_write_sequencer: directed table, corner
// sequences and random traffic against a queue-based reference model.
module tb_regfile_write_sequencer;
    import regfile_write_sequencer_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            hold;
    logic [AW-1:0]   rd_addr1, rd_addr2;
    logic            fwd1_hit, fwd2_hit;
    logic [XLEN-1:0] fwd1_data, fwd2_data;
    logic [2:0]      occupancy;
    logic            empty;

    regfile_write_sequencer_if bus ();

    regfile_write_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .hold      (hold),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .occupancy (occupancy),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    rf_wr_t q[$];

    typedef struct {
        logic            v;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            h;
        logic [AW-1:0]   r1, r2;
        logic            we;
        logic [AW-1:0]   a3;
        logic [XLEN-1:0] wd3;
        logic [2:0]      occ;
        logic            rdy;
        logic            f1h;
        logic [XLEN-1:0] f1d;
        logic            f2h;
        logic [XLEN-1:0] f2d;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                         input logic h, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bus.wr_valid = v;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        hold         = h;
        rd_addr1     = r1;
        rd_addr2     = r2;
    endtask

    // Youngest queued write to addr, x0 never matches
    task automatic model_fwd(input logic [AW-1:0] addr, output logic hit, output logic [XLEN-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (addr != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].addr == addr) begin
                    hit  = 1'b1;
                    data = q[i].data;
                    break;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic            h1, h2;
        logic [XLEN-1:0] d1, d2;
        model_fwd(rd_addr1, h1, d1);
        model_fwd(rd_addr2, h2, d2);
        chk({tag, ".wr_ready"},  bus.wr_ready, q.size() < DEPTH);
        chk({tag, ".rf_we"},     bus.rf_we,    (q.size() > 0) && !hold);
        chk({tag, ".rf_a3"},     bus.rf_a3,    (q.size() > 0) ? q[0].addr : '0);
        chk({tag, ".rf_wd3"},    bus.rf_wd3,   (q.size() > 0) ? q[0].data : '0);
        chk({tag, ".occupancy"}, occupancy,    q.size());
        chk({tag, ".empty"},     empty,        q.size() == 0);
        chk({tag, ".fwd1"},      {fwd1_hit, fwd1_data}, {h1, d1});
        chk({tag, ".fwd2"},      {fwd2_hit, fwd2_data}, {h2, d2});
    endtask

    // Apply the clock-edge effect of the current inputs to the model
    task automatic model_edge();
        logic acc;
        acc = bus.wr_valid && (q.size() < DEPTH);
        if ((q.size() > 0) && !hold) void'(q.pop_front());
        if (acc && (bus.wr_addr != 0)) q.push_back('{addr: bus.wr_addr, data: bus.wr_data});
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_model(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        rst = 1'b1;
        #2;
        chk("reset.rf_we", bus.rf_we, 0);
        chk("reset.rf_a3", bus.rf_a3, 0);
        chk("reset.rf_wd3", bus.rf_wd3, 0);
        chk("reset.occupancy", occupancy, 0);
        chk("reset.empty", empty, 1);
        chk("reset.wr_ready", bus.wr_ready, 1);
        chk("reset.fwd", {fwd1_hit, fwd1_data, fwd2_hit, fwd2_data}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // v a d h r1 r2 | we a3 wd3 occ rdy f1h f1d f2h f2d
        vt[0] = '{1, 5, 32'hDEADBEEF, 0, 5, 0, 0, 0, 0,            0, 1, 0, 0,            0, 0};
        vt[1] = '{0, 0, 0,            0, 5, 5, 1, 5, 32'hDEADBEEF, 1, 1, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF};
        vt[2] = '{1, 7, 32'hA,        1, 7, 0, 0, 0, 0,            0, 1, 0, 0,            0, 0};
        vt[3] = '{1, 7, 32'hB,        1, 7, 0, 0, 7, 32'hA,        1, 1, 1, 32'hA,        0, 0};
        vt[4] = '{0, 0, 0,            1, 7, 0, 0, 7, 32'hA,        2, 1, 1, 32'hB,        0, 0};
        vt[5] = '{0, 0, 0,            0, 7, 0, 1, 7, 32'hA,        2, 1, 1, 32'hB,        0, 0};
        vt[6] = '{1, 0, 32'hFFFFFFFF, 0, 7, 0, 1, 7, 32'hB,        1, 1, 1, 32'hB,        0, 0};
        vt[7] = '{0, 0, 0,            0, 7, 0, 0, 0, 0,            0, 1, 0, 0,            0, 0};
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].v, vt[i].a, vt[i].d, vt[i].h, vt[i].r1, vt[i].r2);
            @(negedge clk);
            chk($sformatf("vec%0d.rf_we", i),     bus.rf_we,    vt[i].we);
            chk($sformatf("vec%0d.rf_a3", i),     bus.rf_a3,    vt[i].a3);
            chk($sformatf("vec%0d.rf_wd3", i),    bus.rf_wd3,   vt[i].wd3);
            chk($sformatf("vec%0d.occupancy", i), occupancy,    vt[i].occ);
            chk($sformatf("vec%0d.wr_ready", i),  bus.wr_ready, vt[i].rdy);
            chk($sformatf("vec%0d.fwd1", i), {fwd1_hit, fwd1_data}, {vt[i].f1h, vt[i].f1d});
            chk($sformatf("vec%0d.fwd2", i), {fwd2_hit, fwd2_data}, {vt[i].f2h, vt[i].f2d});
            model_edge();
            @(posedge clk); #1;
        end

        // Fill under hold, then release: four in-order commits
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, AW'(i), XLEN'(i * 'h11), 1'b1, 5'd3, 5'd4);
            cycle("fill");
        end
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 5'd9);
        @(negedge clk);
        chk("full.wr_ready", bus.wr_ready, 0);
        chk("full.occupancy", occupancy, 4);
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, '0, '0, 1'b0, 5'd3, 5'd4);
            @(negedge clk);
            chk("drain.rf_a3", bus.rf_a3, i);
            chk("drain.rf_wd3", bus.rf_wd3, i * 'h11);
            check_model("drain");
            model_edge();
            @(posedge clk); #1;
        end
        cycle("drained");

        // Async reset mid-cycle with three entries pending
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(10 + i), XLEN'(32'h100 + i), 1'b1, 5'd10, 5'd12);
            cycle("prefill");
        end
        drive(1'b0, '0, '0, 1'b1, 5'd10, 5'd12);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.occupancy", occupancy, 0);
        chk("async_rst.empty", empty, 1);
        chk("async_rst.wr_ready", bus.wr_ready, 1);
        chk("async_rst.rf", {bus.rf_we, bus.rf_a3, bus.rf_wd3}, 0);
        chk("async_rst.fwd", {fwd1_hit, fwd1_data, fwd2_hit, fwd2_data}, 0);
        q.delete();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 5'd10, 5'd12);
        for (int i = 0; i < 3; i++) cycle("post_rst");

        // Full with hold=0 and valid held high: one stall cycle, then wrap
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AW'(20 + i), XLEN'($urandom), 1'b1, 5'd20, 5'd23);
            cycle("fill2");
        end
        drive(1'b1, 5'd24, 32'h2424, 1'b0, 5'd24, 5'd20);
        @(negedge clk);
        chk("stall.wr_ready", bus.wr_ready, 0);
        check_model("stall");
        model_edge();
        @(posedge clk); #1;
        chk("stall_after.wr_ready", bus.wr_ready, 1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, AW'(1 + (i % 31)), XLEN'($urandom), 1'b0, AW'(1 + (i % 31)), 5'd24);
            cycle("wrap");
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) cycle("wrap_drain");

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), XLEN'($urandom),
                  $urandom_range(0, 9) < 3, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
